// File: rtl/reg_bank_pkg.sv
// Shared CPU constants: register indices, $sp reset value and dump FSM encoding.
package reg_bank_pkg;

  // Register indices; the RegDst mux uses the same constants.
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  // Top of stack in the data memory word address space.
  localparam int unsigned SP_RESET = 227;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } dump_state_e;

endpackage

// File: rtl/reg_dump_scanner.sv
// Debug dump scanner: walks register indices 0..NREG-1, one per cycle, after a start pulse.
module reg_dump_scanner
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dump_start,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  dump_state_e state_q;

  // FSM with registered outputs; start pulses during a scan are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dump_start) begin
            state_q    <= SCAN;
            dump_busy  <= 1'b1;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
          end
        end
        SCAN: begin
          if (dump_idx == ADDR_W'(NREG - 1)) begin
            state_q    <= IDLE;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
          end else begin
            dump_idx <= dump_idx + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          dump_busy  <= 1'b0;
          dump_valid <= 1'b0;
          dump_idx   <= '0;
        end
      endcase
    end
  end

  // Live register contents at the current scan index.
  always_comb begin
    dump_data = rd_data;
  end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS register file with hardwired $zero, preset $sp and a debug dump port.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREG     = 32,
  parameter int unsigned SP_IDX   = REG_SP,
  parameter int unsigned SP_RESET = reg_bank_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] dump_rd;

  // Storage: reset clears all but $sp; writes to $zero are dropped so reg 0 stays 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (RegWrite && (WriteReg != ADDR_W'(REG_ZERO))) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  // Zero-latency reads with no write bypass; the dump port shares the same array.
  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    ReadData2 = regs_q[ReadReg2];
    dump_rd   = regs_q[dump_idx];
  end

  reg_dump_scanner #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scanner (
    .clk        (clk),
    .reset_n    (reset_n),
    .dump_start (dump_start),
    .rd_data    (dump_rd),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank against an array-based reference model.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        dump_start = 1'b0;
  logic        dump_busy;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  logic [31:0] model [32];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[29] = 32'd227;
  endtask

  // Advance one clock: commit the applied write into the model, return at the falling edge.
  task automatic step();
    @(posedge clk);
    if (RegWrite && WriteReg != 5'd0) model[WriteReg] = WriteData;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; WriteReg = a; WriteData = d;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 1; i < 32; i++) write_reg(5'(i), $urandom);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    total++;
    if (dump_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%0b exp=0", dump_busy);
    end
    model_reset();
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      #0.1;
      total++;
      if (ReadData1 !== model[i]) begin
        bad++; $display("FAIL reset_reg%0d got=%h exp=%h", i, ReadData1, model[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg2 = 5'd8;
    #1;
    total++;
    if (ReadData2 !== 32'd0) begin
      bad++; $display("FAIL no_bypass got=%h exp=%h", ReadData2, 32'd0);
    end
    step();
    RegWrite = 1'b0; ReadReg1 = 5'd8;
    #1;
    total++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_read got=%h exp=deadbeef", ReadData1);
    end
    total++;
    if (ReadData2 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL same_addr_both got=%h exp=deadbeef", ReadData2);
    end
  endtask

  task automatic test_zero();
    write_reg(5'd0, 32'hFFFFFFFF);
    ReadReg1 = 5'd0;
    #1;
    total++;
    if (ReadData1 !== 32'd0) begin
      bad++; $display("FAIL zero_reg got=%h exp=0", ReadData1);
    end
    RegWrite = 1'b0; WriteReg = 5'd9; WriteData = 32'd5;
    step();
    ReadReg2 = 5'd9;
    #1;
    total++;
    if (ReadData2 !== model[9]) begin
      bad++; $display("FAIL no_write_en got=%h exp=%h", ReadData2, model[9]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      RegWrite = 1'($urandom); WriteReg = 5'($urandom); WriteData = $urandom;
      ReadReg1 = 5'($urandom); ReadReg2 = (n % 5 == 0) ? WriteReg : 5'($urandom);
      #1;
      total++;
      if (ReadData1 !== model[ReadReg1] || ReadData2 !== model[ReadReg2]) begin
        bad++;
        $display("FAIL rand_read r1=%0d got=%h exp=%h r2=%0d got=%h exp=%h", ReadReg1,
                 ReadData1, model[ReadReg1], ReadReg2, ReadData2, model[ReadReg2]);
      end
      step();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_dump();
    for (int n = 1; n < 32; n++) if (n != 29) write_reg(5'(n), 32'(n * 3));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      dump_start = (k == 10);
      #1;
      total++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== 5'(k) ||
          dump_data !== model[k]) begin
        bad++;
        $display("FAIL dump_k%0d valid=%b busy=%b idx=%0d data=%h exp_idx=%0d exp_data=%h", k,
                 dump_valid, dump_busy, dump_idx, dump_data, k, model[k]);
      end
      step();
    end
    dump_start = 1'b0;
    #1;
    total++;
    if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd0) begin
      bad++; $display("FAIL dump_end busy=%b valid=%b idx=%0d exp 0/0/0",
                      dump_busy, dump_valid, dump_idx);
    end
    step();
    #1;
    total++;
    if (dump_busy !== 1'b0) begin
      bad++; $display("FAIL dump_no_restart busy=%b exp=0", dump_busy);
    end
  endtask

  task automatic test_dump_concurrency();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 19) begin
        RegWrite = 1'b1; WriteReg = 5'd20; WriteData = 32'h1234;
      end else begin
        RegWrite = 1'($urandom); WriteReg = 5'($urandom_range(21, 31)); WriteData = $urandom;
      end
      ReadReg1 = 5'($urandom); ReadReg2 = 5'($urandom);
      #1;
      total++;
      if (dump_idx !== 5'(k) || dump_data !== model[k] || ReadData1 !== model[ReadReg1] ||
          ReadData2 !== model[ReadReg2]) begin
        bad++;
        $display("FAIL conc_k%0d idx=%0d data=%h exp=%h rd1=%h exp=%h rd2=%h exp=%h", k,
                 dump_idx, dump_data, model[k], ReadData1, model[ReadReg1], ReadData2,
                 model[ReadReg2]);
      end
      if (k == 20) begin
        total++;
        if (dump_data !== 32'h1234) begin
          bad++; $display("FAIL conc_live20 got=%h exp=00001234", dump_data);
        end
      end
      step();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 15; k++) step();
    #1;
    total++;
    if (dump_idx !== 5'd15) begin
      bad++; $display("FAIL mid_idx got=%0d exp=15", dump_idx);
    end
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0) begin
      bad++; $display("FAIL mid_abort valid=%b busy=%b idx=%0d exp 0/0/0",
                      dump_valid, dump_busy, dump_idx);
    end
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      #0.1;
      total++;
      if (ReadData1 !== model[i]) begin
        bad++; $display("FAIL mid_reset_reg%0d got=%h exp=%h", i, ReadData1, model[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      total++;
      if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle busy=%b valid=%b exp 0/0", dump_busy, dump_valid);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero();
    test_random();
    test_dump();
    test_dump_concurrency();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32 x 32-bit MIPS general register file for the multicycle datapath.
- Sits directly downstream of the RegDst destination mux: the mux output drives WriteReg; rs/rt fields of the instruction register drive the read addresses.
- Hardwires $zero and presets $sp on reset.
- Adds a sequential debug dump scanner that streams all 32 registers, one per cycle, for the testbench and board display.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width
- NREG, 32, number of registers (must equal 2**ADDR_W)
- SP_IDX, 29, index of $sp
- SP_RESET, 227, reset value of $sp (top of stack, word address space of data memory)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- RegWrite  in  1  write enable from control unit
- WriteReg  in  ADDR_W  destination index (from RegDst mux)
- WriteData  in  DATA_W  data to write (from MemtoReg mux)
- ReadReg1  in  ADDR_W  read port A index (rs)
- ReadReg2  in  ADDR_W  read port B index (rt)
- ReadData1  out  DATA_W  read port A data
- ReadData2  out  DATA_W  read port B data
- dump_start  in  1  pulse: begin register dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_idx/dump_data valid this cycle
- dump_idx  out  ADDR_W  index being dumped
- dump_data  out  DATA_W  contents of register dump_idx

Behaviour:
- Reset (reset_n low, async, takes effect immediately):
  - All registers cleared to 0, except reg[SP_IDX] = SP_RESET.
  - Dump FSM forced to IDLE; dump_busy = 0, dump_valid = 0, dump_idx = 0.
- Write:
  - On a rising clk with RegWrite = 1 and WriteReg != 0, reg[WriteReg] <= WriteData.
  - Writes to index 0 are discarded; reg[0] reads 0 always.
  - RegWrite = 0: no state change.
- Read:
  - ReadData1/2 are combinational, zero latency: reg[ReadReg1] and reg[ReadReg2].
  - No write bypass. A read of the register being written in the same cycle returns the OLD value until after the edge; the multicycle control never relies on bypass.
  - Both ports may address the same register; both return the same value.
- Dump FSM, two states: IDLE, SCAN.
  - IDLE: dump_busy = 0, dump_valid = 0.
    - dump_start = 1 at an edge -> SCAN, dump_idx <= 0, dump_busy <= 1, dump_valid <= 1.
  - SCAN: dump_valid = 1.
    - Each edge dump_idx <= dump_idx + 1.
    - When dump_idx = NREG-1 at an edge -> IDLE, dump_busy <= 0, dump_valid <= 0, dump_idx <= 0.
    - Exactly NREG valid cycles per dump.
  - dump_start while in SCAN is ignored. No restart and no queuing.
  - dump_data = reg[dump_idx], read combinationally. It reflects live contents: a write committed at the edge that enters a cycle is visible in that cycle's dump_data.
  - Dump never blocks or delays normal reads/writes.
  - Reset mid-scan aborts to IDLE at once. A new dump_start is needed afterwards.
- Widths:
  - dump_idx increments modulo 2**ADDR_W. The wrap is never reached because the SCAN exit occurs at NREG-1.

Decomposition:
- Shared CPU package holds:
  - Register index constants REG_ZERO = 0, REG_SP = 29, REG_RA = 31. These same constants are used by the RegDst mux.
  - SP_RESET.
  - Dump FSM state encoding: IDLE = 1'b0, SCAN = 1'b1.
- One natural sub-module: reg_dump_scanner. It contains the FSM and the index counter, outputs dump_idx/valid/busy, and takes the register array read as input.
- The storage array and write logic stay in reg_bank.

Test Plan:
- Reset: pulse reset_n low asynchronously mid-cycle -> immediately ReadData for idx 29 = 227, idx 0/5/31 = 0, dump_busy = 0.
- Write/read: RegWrite = 1, WriteReg = 8, WriteData = 0xDEADBEEF, one edge -> ReadReg1 = 8 gives 0xDEADBEEF. In the same cycle before the edge, ReadReg2 = 8 still gives 0.
- $zero: RegWrite = 1, WriteReg = 0, WriteData = 0xFFFFFFFF -> ReadData1 (ReadReg1 = 0) stays 0. Also RegWrite = 0, WriteReg = 9, data 5 -> reg 9 unchanged.
- Dump:
  - Preload reg[n] = n*3 for n = 1..31 (except 29), pulse dump_start.
  - Expect 32 consecutive cycles with dump_valid = 1 and dump_idx 0..31, dump_data = reg[idx] (idx 29 = 227).
  - Then dump_busy = 0.
  - A second dump_start pulse at dump_idx = 10 has no effect.
- Dump concurrency: during SCAN write reg[20] = 0x1234 at the edge entering dump_idx = 20 -> dump_data = 0x1234 in that cycle. Normal reads remain correct throughout.
- Reset mid-dump: reset_n low at dump_idx = 15 -> dump_valid/busy drop at once, all registers back to reset values, FSM idle until the next dump_start.
